// File: rtl/sram_sp_ctrl_pkg.sv
// sram_sp_ctrl_pkg: shared definitions for the single-port SRAM controller.
// State encodings, legal read-latency range and the log2 helper used to size
// address and counter widths.
package sram_sp_ctrl_pkg;

   typedef enum logic [0:0] {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   localparam int RD_LAT_MIN = 1;
   localparam int RD_LAT_MAX = 2;

   // Ceiling log2 of a positive value (1 -> 0, 2 -> 1, 256 -> 8).
   function automatic int func_log2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((32'd1 << i) < 32'(value)) begin
            r = i + 1;
         end else begin
            r = r;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/sram_sp_ctrl_rsp_fifo.sv
// sram_sp_ctrl_rsp_fifo: synchronous first-word-fall-through FIFO.
// The head entry is visible on o_head_dat whenever o_empty is low. Push and pop
// may happen in the same cycle at any occupancy, including full. The storage is
// cleared by reset so the head output reads zero after rst.
module sram_sp_ctrl_rsp_fifo
   import sram_sp_ctrl_pkg::*;
#(
   parameter  int DEPTH   = 4,
   parameter  int DATA_WD = 32,
   localparam int AW      = func_log2(DEPTH),
   localparam int CW      = AW + 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_push,
   input  logic [DATA_WD-1:0] i_push_dat,
   input  logic               i_pop,
   output logic [DATA_WD-1:0] o_head_dat,
   output logic [CW-1:0]      o_count,
   output logic               o_full,
   output logic               o_empty
);

   logic [DATA_WD-1:0] r_mem [DEPTH];
   logic [AW-1:0]      r_wr_ptr;
   logic [AW-1:0]      r_rd_ptr;
   logic [CW-1:0]      r_count;
   logic               w_do_push;
   logic               w_do_pop;

   // Qualify push/pop against occupancy; a pop frees the slot a full push needs.
   always_comb begin
      o_full     = (r_count == CW'(DEPTH));
      o_empty    = (r_count == '0);
      o_count    = r_count;
      o_head_dat = r_mem[r_rd_ptr];
      w_do_pop   = i_pop & ~o_empty;
      w_do_push  = i_push & (~o_full | w_do_pop);
   end

   // Storage, pointers and occupancy counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_dat;
            r_wr_ptr        <= r_wr_ptr + AW'(1);
         end else begin
            r_wr_ptr <= r_wr_ptr;
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end else begin
            r_rd_ptr <= r_rd_ptr;
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/sram_sp_ctrl.sv
// sram_sp_ctrl: initiator-side controller for a single-port SRAM macro.
// Turns a valid/ready request stream into one SRAM access per cycle and
// buffers read returns in a response FIFO. Reads are credit-gated so every
// word the SRAM returns already owns a FIFO slot.
// Optional build macro SRAM_SP_CTRL_INIT_EN: after reset, zero-fill every
// SRAM word (one per cycle) before accepting requests.
module sram_sp_ctrl
   import sram_sp_ctrl_pkg::*;
#(
   parameter  int SIZE      = 256,
   parameter  int DATA_WD   = 32,
   parameter  int RD_LAT    = 1,
   parameter  int RSP_DEPTH = 4,
   localparam int SIZE_WD   = func_log2(SIZE)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               req_val_i,
   output logic               req_rdy_o,
   input  logic               req_wr_i,
   input  logic [SIZE_WD-1:0] req_adr_i,
   input  logic [DATA_WD-1:0] req_dat_i,
   output logic               rsp_val_o,
   input  logic               rsp_rdy_i,
   output logic [DATA_WD-1:0] rsp_dat_o,
   output logic               init_done_o,
   output logic               ovf_err_o,
   output logic [SIZE_WD-1:0] sram_adr_o,
   output logic               sram_wr_val_o,
   output logic [DATA_WD-1:0] sram_wr_dat_o,
   output logic               sram_rd_val_o,
   input  logic               sram_rd_val_i,
   input  logic [DATA_WD-1:0] sram_rd_dat_i
);

   localparam int          CW         = func_log2(RSP_DEPTH) + 1;
   localparam logic [CW:0] CREDIT_MAX = (CW + 1)'(RSP_DEPTH);
   // An unsupported read latency keeps the request port closed.
   localparam bit          RD_LAT_OK  = (RD_LAT >= RD_LAT_MIN) && (RD_LAT <= RD_LAT_MAX);

`ifdef SRAM_SP_CTRL_INIT_EN
   localparam state_t ST_RESET = ST_INIT;
`else
   localparam state_t ST_RESET = ST_RUN;
`endif

   state_t             r_state;
   logic               r_init_done;
   logic               r_ovf_err;
   logic [CW-1:0]      r_inflight;
   logic [CW-1:0]      w_inflight_nxt;
   logic [CW:0]        w_credit_sum;
   logic               w_fire;
   logic               w_rd_issue;
   logic               w_push;
   logic               w_pop;
   logic               w_ovf;
   logic               w_init_wr;
   logic [SIZE_WD-1:0] w_init_adr;
   logic [CW-1:0]      w_fifo_cnt;
   logic               w_fifo_full;
   logic               w_fifo_empty;

`ifdef SRAM_SP_CTRL_INIT_EN
   logic [SIZE_WD-1:0] r_init_cnt;

   // Zero-fill sweep address; suppressed while reset is held.
   always_comb begin
      w_init_wr  = (r_state == ST_INIT) & ~rst;
      w_init_adr = r_init_cnt;
   end
`else
   // No zero-fill sweep in this build.
   always_comb begin
      w_init_wr  = 1'b0;
      w_init_adr = '0;
   end
`endif

   // Credit check, request handshake and response-side push/pop/overflow.
   always_comb begin
      w_credit_sum = {1'b0, r_inflight} + {1'b0, w_fifo_cnt};
      req_rdy_o    = r_init_done & (r_state == ST_RUN) & RD_LAT_OK & (w_credit_sum < CREDIT_MAX);
      w_fire       = req_val_i & req_rdy_o;
      w_rd_issue   = w_fire & ~req_wr_i;
      rsp_val_o    = ~w_fifo_empty;
      w_pop        = rsp_val_o & rsp_rdy_i;
      w_ovf        = sram_rd_val_i & ((w_fifo_full & ~w_pop) | (r_inflight == '0));
      w_push       = sram_rd_val_i & ~w_ovf;
      init_done_o  = r_init_done;
      ovf_err_o    = r_ovf_err;
   end

   // SRAM port drive: the accepted request, else the zero-fill sweep, else idle.
   always_comb begin
      sram_adr_o    = '0;
      sram_wr_val_o = 1'b0;
      sram_wr_dat_o = '0;
      sram_rd_val_o = 1'b0;
      if (w_fire) begin
         sram_adr_o    = req_adr_i;
         sram_wr_val_o = req_wr_i;
         sram_wr_dat_o = req_wr_i ? req_dat_i : '0;
         sram_rd_val_o = ~req_wr_i;
      end else begin
         sram_adr_o    = w_init_adr;
         sram_wr_val_o = w_init_wr;
      end
   end

   // Outstanding-read count: +1 on issue, -1 on return (never below zero).
   always_comb begin
      w_inflight_nxt = r_inflight;
      case ({w_rd_issue, sram_rd_val_i})
         2'b10: w_inflight_nxt = r_inflight + CW'(1);
         2'b01: begin
            if (r_inflight != '0) begin
               w_inflight_nxt = r_inflight - CW'(1);
            end else begin
               w_inflight_nxt = r_inflight;
            end
         end
         default: w_inflight_nxt = r_inflight;
      endcase
   end

   // Controller FSM, sticky overflow flag and in-flight counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_RESET;
         r_init_done <= 1'b0;
         r_ovf_err   <= 1'b0;
         r_inflight  <= '0;
`ifdef SRAM_SP_CTRL_INIT_EN
         r_init_cnt  <= '0;
`endif
      end else begin
         case (r_state)
            ST_INIT: begin
`ifdef SRAM_SP_CTRL_INIT_EN
               r_init_cnt <= r_init_cnt + SIZE_WD'(1);
               if (r_init_cnt == SIZE_WD'(SIZE - 1)) begin
                  r_state <= ST_RUN;
               end else begin
                  r_state <= ST_INIT;
               end
`else
               r_state <= ST_RUN;
`endif
            end
            ST_RUN:  r_state <= ST_RUN;
            default: r_state <= ST_RUN;
         endcase
         r_init_done <= (r_state == ST_RUN);
         r_ovf_err   <= r_ovf_err | w_ovf;
         r_inflight  <= w_inflight_nxt;
      end
   end

   sram_sp_ctrl_rsp_fifo #(
      .DEPTH   (RSP_DEPTH),
      .DATA_WD (DATA_WD)
   ) u_rsp_fifo (
      .clk        (clk),
      .rst        (rst),
      .i_push     (w_push),
      .i_push_dat (sram_rd_dat_i),
      .i_pop      (w_pop),
      .o_head_dat (rsp_dat_o),
      .o_count    (w_fifo_cnt),
      .o_full     (w_fifo_full),
      .o_empty    (w_fifo_empty)
   );

endmodule

// File: tb/tb_sram_sp_ctrl.sv
// tb_sram_sp_ctrl: directed bench for sram_sp_ctrl with SIZE=16, RD_LAT=2,
// RSP_DEPTH=4 and a behavioural SRAM model. Also exercises the zero-fill
// sweep when SRAM_SP_CTRL_INIT_EN is defined.
module tb_sram_sp_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_val_i;
   logic        req_rdy_o;
   logic        req_wr_i;
   logic [3:0]  req_adr_i;
   logic [31:0] req_dat_i;
   logic        rsp_val_o;
   logic        rsp_rdy_i;
   logic [31:0] rsp_dat_o;
   logic        init_done_o;
   logic        ovf_err_o;
   logic [3:0]  sram_adr_o;
   logic        sram_wr_val_o;
   logic [31:0] sram_wr_dat_o;
   logic        sram_rd_val_o;
   logic        sram_rd_val_i;
   logic [31:0] sram_rd_dat_i;

   int n_chk  = 0;
   int n_err  = 0;
   int n_both = 0;

   // SRAM model: two-cycle read latency, pipeline cleared by rst.
   logic [31:0] mem [16];
   logic [1:0]  pv;
   logic [31:0] pd0, pd1;
   logic        force_rv;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (sram_wr_val_o) mem[sram_adr_o] <= sram_wr_dat_o;
      if (rst) begin
         pv <= 2'b00;
      end else begin
         pv[0] <= sram_rd_val_o;
         pv[1] <= pv[0];
      end
      pd0 <= mem[sram_adr_o];
      pd1 <= pd0;
   end

   assign sram_rd_val_i = pv[1] | force_rv;
   assign sram_rd_dat_i = pd1;

   always @(negedge clk) begin
      if (sram_wr_val_o && sram_rd_val_o) n_both++;
   end

   sram_sp_ctrl #(
      .SIZE      (16),
      .DATA_WD   (32),
      .RD_LAT    (2),
      .RSP_DEPTH (4)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .req_val_i     (req_val_i),
      .req_rdy_o     (req_rdy_o),
      .req_wr_i      (req_wr_i),
      .req_adr_i     (req_adr_i),
      .req_dat_i     (req_dat_i),
      .rsp_val_o     (rsp_val_o),
      .rsp_rdy_i     (rsp_rdy_i),
      .rsp_dat_o     (rsp_dat_o),
      .init_done_o   (init_done_o),
      .ovf_err_o     (ovf_err_o),
      .sram_adr_o    (sram_adr_o),
      .sram_wr_val_o (sram_wr_val_o),
      .sram_wr_dat_o (sram_wr_dat_o),
      .sram_rd_val_o (sram_rd_val_o),
      .sram_rd_val_i (sram_rd_val_i),
      .sram_rd_dat_i (sram_rd_dat_i)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Issue one request (called at posedge+2); returns at posedge+2 after acceptance.
   task automatic send(input logic wr, input logic [3:0] adr, input logic [31:0] dat);
      int n;
      n = 0;
      req_val_i = 1'b1;
      req_wr_i  = wr;
      req_adr_i = adr;
      req_dat_i = dat;
      #1;
      while (!req_rdy_o && n < 50) begin
         @(posedge clk); #2;
         n++;
      end
      chk("send_accept", 32'(n < 50), 32'd1);
      @(posedge clk); #2;
      req_val_i = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_req_rdy"},   32'(req_rdy_o),     32'd0);
      chk({tag, "_rsp_val"},   32'(rsp_val_o),     32'd0);
      chk({tag, "_rsp_dat"},   rsp_dat_o,          32'd0);
      chk({tag, "_init_done"}, 32'(init_done_o),   32'd0);
      chk({tag, "_ovf"},       32'(ovf_err_o),     32'd0);
      chk({tag, "_sram_rd"},   32'(sram_rd_val_o), 32'd0);
      chk({tag, "_sram_adr"},  32'(sram_adr_o),    32'd0);
      chk({tag, "_sram_wdat"}, sram_wr_dat_o,      32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not reach the summary");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int  nxt;
      int  got;
      logic fired;
      rst       = 1'b1;
      req_val_i = 1'b0;
      req_wr_i  = 1'b0;
      req_adr_i = 4'd0;
      req_dat_i = 32'd0;
      rsp_rdy_i = 1'b0;
      force_rv  = 1'b0;

      // Reset values while rst is held.
      @(posedge clk); #3;
      check_reset_outputs("rst");
      chk("rst_sram_wr", 32'(sram_wr_val_o), 32'd0);
      @(posedge clk); #2;
      rst = 1'b0;
      #1;
      chk("post_rst_init_done", 32'(init_done_o), 32'd0);
      chk("post_rst_req_rdy",   32'(req_rdy_o),   32'd0);

`ifdef SRAM_SP_CTRL_INIT_EN
      // Zero-fill sweep: one write of 0 per cycle to adr 0..15, no requests taken.
      for (int k = 0; k < 16; k++) begin
         if (k != 0) #1;
         chk("init_wr_val", 32'(sram_wr_val_o), 32'd1);
         chk("init_adr",    32'(sram_adr_o),    32'(k));
         chk("init_wdat",   sram_wr_dat_o,      32'd0);
         chk("init_rdy",    32'(req_rdy_o),     32'd0);
         @(posedge clk); #2;
      end
      #1;
      chk("init_done_c16", 32'(init_done_o), 32'd0);
      @(posedge clk); #2;
      #1;
      chk("init_done_c17", 32'(init_done_o), 32'd1);
      // Read back a swept word.
      send(1'b0, 4'd9, 32'd0);
      @(posedge clk); #2;
      @(posedge clk); #2;
      #1;
      chk("init_rd9_val", 32'(rsp_val_o), 32'd1);
      chk("init_rd9_dat", rsp_dat_o,      32'd0);
      rsp_rdy_i = 1'b1;
      @(posedge clk); #2;
      rsp_rdy_i = 1'b0;
`else
      @(posedge clk); #2;
      #1;
      chk("run_init_done", 32'(init_done_o), 32'd1);
      chk("run_req_rdy",   32'(req_rdy_o),   32'd1);
`endif

      // Write then read the same address on consecutive cycles.
      send(1'b1, 4'd3, 32'hA5A5_0001);
      send(1'b0, 4'd3, 32'd0);
      #1;
      chk("raw_lat_t1", 32'(rsp_val_o), 32'd0);
      @(posedge clk); #2;
      #1;
      chk("raw_lat_t2", 32'(rsp_val_o), 32'd0);
      @(posedge clk); #2;
      #1;
      chk("raw_lat_t3_val", 32'(rsp_val_o), 32'd1);
      chk("raw_lat_t3_dat", rsp_dat_o,      32'hA5A5_0001);
      rsp_rdy_i = 1'b1;
      @(posedge clk); #2;
      rsp_rdy_i = 1'b0;
      #1;
      chk("raw_popped", 32'(rsp_val_o), 32'd0);

      // Fill adr 0..7 with their own index.
      for (int i = 0; i < 8; i++) begin
         send(1'b1, 4'(i), 32'(i));
      end

      // Back-to-back reads with the response side stalled: four credits only.
      req_val_i = 1'b1;
      req_wr_i  = 1'b0;
      for (int i = 0; i < 4; i++) begin
         req_adr_i = 4'(i);
         #1;
         chk("burst_rdy", 32'(req_rdy_o), 32'd1);
         @(posedge clk); #2;
      end
      req_adr_i = 4'd4;
      for (int h = 0; h < 6; h++) begin
         #1;
         chk("full_rdy_low", 32'(req_rdy_o), 32'd0);
         chk("full_no_ovf",  32'(ovf_err_o), 32'd0);
         chk("full_head",    rsp_dat_o,      32'd0);
         @(posedge clk); #2;
      end
      #1;
      chk("full_rsp_val", 32'(rsp_val_o), 32'd1);

      // Release backpressure: data 0..7 in order, reads 4..7 accepted as credits free.
      rsp_rdy_i = 1'b1;
      nxt = 4;
      got = 0;
      for (int c = 0; c < 80 && got < 8; c++) begin
         if (rsp_val_o) begin
            chk("rsp_order", rsp_dat_o, 32'(got));
            got++;
         end
         fired = req_val_i & req_rdy_o;
         @(posedge clk); #2;
         if (fired) begin
            nxt++;
            if (nxt < 8) req_adr_i = 4'(nxt);
            else         req_val_i = 1'b0;
         end
         #1;
      end
      chk("rsp_all_returned", 32'(got), 32'd8);
      chk("drain_ovf",        32'(ovf_err_o), 32'd0);
      rsp_rdy_i = 1'b0;
      @(posedge clk); #2;

      // Reset with two reads in flight.
      req_val_i = 1'b1;
      req_wr_i  = 1'b0;
      req_adr_i = 4'd0;
      #1;
      chk("mid_rd0_rdy", 32'(req_rdy_o), 32'd1);
      @(posedge clk); #2;
      req_adr_i = 4'd1;
      #1;
      chk("mid_rd1_rdy", 32'(req_rdy_o), 32'd1);
      @(posedge clk); #2;
      req_val_i = 1'b0;
      rst = 1'b1;
      @(posedge clk); #2;
      rst = 1'b0;
      #1;
      check_reset_outputs("mid_rst");
      for (int c = 0; c < 20; c++) begin
         @(posedge clk); #2;
         #1;
         chk("abandoned_no_rsp", 32'(rsp_val_o), 32'd0);
         chk("abandoned_no_ovf", 32'(ovf_err_o), 32'd0);
      end
      chk("mid_rst_init_done", 32'(init_done_o), 32'd1);

      // Stray SRAM return with nothing outstanding.
      force_rv = 1'b1;
      @(posedge clk); #2;
      force_rv = 1'b0;
      #1;
      chk("ovf_set",      32'(ovf_err_o), 32'd1);
      chk("ovf_no_push",  32'(rsp_val_o), 32'd0);
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #2;
         #1;
         chk("ovf_sticky", 32'(ovf_err_o), 32'd1);
      end

      chk("no_wr_rd_overlap", 32'(n_both), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/sram_sp_ctrl.md
Name: sram_sp_ctrl

Overview:
Initiator-side controller for the single-port SRAM simulation/macro interface (adr, wr_val, wr_dat, rd_val in; rd_val, rd_dat back).
- Upstream: converts a valid/ready request stream into one SRAM access per cycle.
- Downstream: buffers read data returned after a fixed SRAM read latency in a response FIFO with valid/ready backpressure.
- SRAM outputs cannot be stalled, so reads are credit-gated and every returned word has a FIFO slot.
- Sits between a client engine and any sram_sp-style instance.

Parameters:
SIZE, 256, number of SRAM words (power of 2).
DATA_WD, 32, SRAM word width.
RD_LAT, 1, SRAM read latency in cycles (1 = no output register, 2 = registered output); only 1 or 2 legal.
RSP_DEPTH, 4, response FIFO depth (power of 2, >= RD_LAT+1).
SIZE_WD, FUNC_LOG2(SIZE), derived localparam; address width.

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
req_val_i  input  1  request valid
req_rdy_o  output  1  request ready
req_wr_i  input  1  1 = write, 0 = read
req_adr_i  input  SIZE_WD  request address
req_dat_i  input  DATA_WD  write data
rsp_val_o  output  1  read response valid
rsp_rdy_i  input  1  read response ready
rsp_dat_o  output  DATA_WD  read response data
init_done_o  output  1  controller in RUN state
ovf_err_o  output  1  sticky: SRAM returned data with FIFO full or no read outstanding
sram_adr_o  output  SIZE_WD  to SRAM adr_i
sram_wr_val_o  output  1  to SRAM wr_val_i
sram_wr_dat_o  output  DATA_WD  to SRAM wr_dat_i
sram_rd_val_o  output  1  to SRAM rd_val_i
sram_rd_val_i  input  1  from SRAM rd_val_o
sram_rd_dat_i  input  DATA_WD  from SRAM rd_dat_o

Behaviour:
- Clocking and reset: single clock clk; rst is synchronous and active-high. All state updates on posedge clk only.
- Reset values:
  - req_rdy_o=0, rsp_val_o=0, rsp_dat_o=0, init_done_o=0, ovf_err_o=0.
  - sram_wr_val_o=0, sram_rd_val_o=0, sram_adr_o=0, sram_wr_dat_o=0.
  - FIFO empty, inflight count=0, FSM=INIT (or RUN when the optional feature is off).
- FSM states: INIT -> RUN. RUN is terminal until rst.
  - INIT is present only with the optional feature.
  - init_done_o = (state==RUN), registered.
- Request accept:
  - fire = req_val_i & req_rdy_o.
  - req_rdy_o = RUN & (inflight + fifo_cnt < RSP_DEPTH).
  - req_rdy_o is independent of req_val_i and req_wr_i. Writes are also gated, which keeps ordering simple.
- SRAM drive (combinational from fire in RUN):
  - sram_adr_o = req_adr_i.
  - sram_wr_val_o = fire & req_wr_i; sram_wr_dat_o = req_dat_i.
  - sram_rd_val_o = fire & ~req_wr_i.
  - Exactly one access per cycle; never wr and rd together.
- inflight counter:
  - Width FUNC_LOG2(RSP_DEPTH)+1.
  - +1 on read issue, -1 on sram_rd_val_i; both in the same cycle = no change.
  - Decrement saturates at 0.
- Response FIFO:
  - Push on sram_rd_val_i; pop on rsp_val_o & rsp_rdy_i.
  - Simultaneous push/pop allowed at any occupancy.
  - No push-to-output bypass: read accepted at cycle T gives rsp_val_o at cycle T+RD_LAT+1 earliest.
  - rsp_dat_o holds the head entry and is stable while rsp_val_o=1 and rsp_rdy_i=0.
  - Responses come out in issue order.
- ovf_err_o set when sram_rd_val_i=1 and either the FIFO is full without a pop, or inflight=0. Data is dropped and the flag stays set until rst.
- Read-after-write to the same address in consecutive cycles returns the new data.
- Reset mid-operation:
  - Outstanding reads are abandoned. The SRAM is assumed reset on the same edge, so no stale returns.
  - A stray return raises ovf_err_o and is not pushed.

Optional Feature:
Macro SRAM_SP_CTRL_INIT_EN.
- Defined:
  - After rst the FSM is in INIT and sweeps a counter 0..SIZE-1, one word per cycle: sram_wr_val_o=1, sram_wr_dat_o=0.
  - It enters RUN on the cycle after the write to SIZE-1, so init_done_o rises SIZE+1 cycles after rst deasserts.
  - req_rdy_o=0 throughout INIT.
- Not defined: no INIT state. The FSM resets directly into RUN and init_done_o=1 from the first cycle after rst deasserts.

Decomposition:
- Shared package/header: state encodings (ST_INIT, ST_RUN) and the legal RD_LAT values. FUNC_LOG2 continues to come from define.vh.
- One sub-module: sram_sp_ctrl_rsp_fifo.
  - Synchronous FWFT FIFO with parameters DEPTH and DATA_WD.
  - Ports: push/pop, count, full, empty.
  - Reused by other SRAM clients.

Test Plan:
- Write 0xA5A5_0001 to adr 3, then read adr 3 with RD_LAT=1 -> rsp_val_o=1 with rsp_dat_o=0xA5A5_0001 exactly 2 cycles after read accept.
- RD_LAT=2, RSP_DEPTH=4, rsp_rdy_i=0, back-to-back reads of adr 0..7 -> exactly 4 accepted, req_rdy_o=0 after the 4th, ovf_err_o stays 0. Raise rsp_rdy_i -> data 0..3 in order, then remaining reads are accepted.
- Write adr 5 at cycle T, read adr 5 at T+1 -> new data returned; sram_wr_val_o and sram_rd_val_o never high together.
- SRAM_SP_CTRL_INIT_EN defined, SIZE=16 -> req_rdy_o=0 and 16 zero writes to adrs 0..15; init_done_o rises on cycle 17; a subsequent read of adr 9 returns 0.
- Assert rst for 1 cycle while 2 reads are in flight -> all outputs at reset values next cycle, FIFO empty, no rsp_val_o from the abandoned reads.
- Force sram_rd_val_i=1 with inflight=0 -> ovf_err_o=1 next cycle and stays 1; FIFO count unchanged.
